// File: rtl/led_arbiter.sv
// Three-requester round-robin arbiter for a shared 8-bit LED bank.
// Grants honour a minimum hold, are preempted at a maximum hold when contended, and hand off with no idle gap.
module led_arbiter #(
   parameter int MINHOLD = 4,
   parameter int MAXHOLD = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] req,
   input  logic [7:0] data0,
   input  logic [7:0] data1,
   input  logic [7:0] data2,
   output logic [2:0] grant,
   output logic [7:0] led,
   output logic       busy,
   output logic       switch_p
);

   localparam logic [0:0]  IDLE   = 1'b0;
   localparam logic [0:0]  OWN    = 1'b1;
   localparam logic [15:0] MIN_M1 = 16'(MINHOLD - 1);
   localparam logic [15:0] MAX_M1 = 16'(MAXHOLD - 1);

   logic [0:0]  state;
   logic [15:0] hold_cnt;
   logic [1:0]  last;
   logic [1:0]  rst_sync;
   logic        run;

   logic [7:0]  owner_data;
   logic        owner_req;
   logic [2:0]  cand;
   logic        grant_end;
   logic        win_valid;
   logic [1:0]  win_idx;

   // Round-robin search starting after the previous owner; returns {found, index}.
   function automatic logic [2:0] pick(input logic [2:0] m, input logic [1:0] l);
      logic [1:0] a;
      logic [1:0] b;
      a = (l == 2'd2) ? 2'd0 : l + 2'd1;
      b = (a == 2'd2) ? 2'd0 : a + 2'd1;
      if (m[a])      pick = {1'b1, a};
      else if (m[b]) pick = {1'b1, b};
      else if (m[l]) pick = {1'b1, l};
      else           pick = 3'b000;
   endfunction

   // Reset asserts immediately but releases only after two clean edges.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rst_sync <= 2'b00;
      else      rst_sync <= {rst_sync[0], 1'b1};
   end
   assign run = rst_sync[1];

   always_comb begin
      // NOTE: every combinational output gets a default first so no latch can be inferred.
      owner_data = data2;
      case (last)
         2'd0:    owner_data = data0;
         2'd1:    owner_data = data1;
         default: owner_data = data2;
      endcase
      owner_req = req[last];
      // While owning, last is the owner, so masking with grant leaves only the contenders.
      cand      = (state == OWN) ? (req & ~grant) : req;
      grant_end = (state == OWN) &&
                  ((!owner_req && hold_cnt >= MIN_M1) || (hold_cnt == MAX_M1 && cand != 3'b000));
      {win_valid, win_idx} = pick(cand, last);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         grant    <= 3'b000;
         led      <= 8'h00;
         switch_p <= 1'b0;
         hold_cnt <= 16'd0;
         last     <= 2'd2;
      end else if (run) begin
         // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
         switch_p <= 1'b0;
         if (state == IDLE) begin
            if (win_valid) begin
               state    <= OWN;
               grant    <= 3'b001 << win_idx;
               last     <= win_idx;
               hold_cnt <= 16'd0;
               switch_p <= 1'b1;
            end
         end else begin
            led <= owner_data;
            if (grant_end) begin
               if (win_valid) begin
                  grant    <= 3'b001 << win_idx;
                  last     <= win_idx;
                  hold_cnt <= 16'd0;
                  switch_p <= 1'b1;
               end else begin
                  state    <= IDLE;
                  grant    <= 3'b000;
                  hold_cnt <= 16'd0;
               end
            end else if (hold_cnt != MAX_M1) begin
               hold_cnt <= hold_cnt + 16'd1;
            end
         end
      end
   end

   assign busy = |grant;

endmodule

// File: doc/led_arbiter.md
LED_ARBITER -- requirements
Module: led_arbiter

Interface
REQ-001 Parameter MINHOLD, default 4: minimum grant length in clk cycles; legal range 1 or more.
REQ-002 Parameter MAXHOLD, default 16: grant length after which a contended owner is preempted; legal range MINHOLD or more, at most 65535.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 req  input  3  per-requester request for the LED bank; bit i belongs to requester i.
REQ-006 data0, data1, data2  input  8 each  LED pattern offered by requesters 0, 1 and 2.
REQ-007 grant  output  3  one-hot current owner, or 000 when there is no owner.
REQ-008 led  output  8  registered pattern driven to the LED bank.
REQ-009 busy  output  1  high whenever grant is not 000.
REQ-010 switch_p  output  1  one-cycle pulse on the first cycle of every new grant.

Function
REQ-011 The block SHALL implement two states: IDLE (no owner) and OWN (exactly one grant bit high).
REQ-012 The block SHALL keep an internal hold counter hold_cnt, 16 bits wide: 0 on the first cycle of each grant, +1 per cycle while in OWN, saturating at MAXHOLD-1.
REQ-013 The block SHALL keep a round-robin pointer last holding the index of the most recent owner.
REQ-014 Arbitration order SHALL be last+1, last+2, last (mod 3); the first requester in that order with req high wins.
REQ-015 IDLE with req != 000: on the next edge, grant = one-hot(winner), state = OWN, hold_cnt = 0, last = winner, switch_p = 1.
REQ-016 IDLE with req == 000: grant stays 000 and led holds its last value.
REQ-017 OWN: led SHALL register the granted requester's data every cycle, giving one-cycle latency from data to led; the first led update appears on the edge after grant rises.
REQ-018 Release: in OWN, if the owner's req is low and hold_cnt >= MINHOLD-1, the grant SHALL end at the next edge; the minimum grant is therefore MINHOLD cycles.
REQ-019 If the owner's req drops while hold_cnt < MINHOLD-1, the grant SHALL be retained and led SHALL keep tracking the owner's data until the release condition of REQ-018 holds.
REQ-020 Preemption: in OWN, if hold_cnt == MAXHOLD-1 and any other req is high, the grant SHALL end at the next edge even if the owner's req is still high; the maximum contended grant is MAXHOLD cycles.
REQ-021 Uncontended owner: if the owner's req is high and no other req is high, the grant SHALL continue indefinitely with hold_cnt saturated.
REQ-022 Handoff: when a grant ends (release or preemption) and any other req is high, the next winner per REQ-014 SHALL be granted on the same edge, with no IDLE gap, hold_cnt = 0 and switch_p = 1.
REQ-023 When a grant ends with no other req pending, the block SHALL go to IDLE; the owner's own req high at that edge SHALL NOT be re-granted on that edge.
REQ-024 Simultaneous requests from IDLE SHALL be resolved purely by REQ-014.
REQ-025 grant SHALL never have more than one bit high.
REQ-026 busy SHALL equal OR(grant) with zero-cycle relation to grant.
REQ-027 switch_p SHALL be high for exactly one cycle per new grant, including each handoff.
REQ-028 Changes on req or data SHALL affect outputs only through registers; no output has a combinational path from any input.

Reset
REQ-029 While rst is low: grant = 000, led = 00000000, busy = 0, switch_p = 0, state = IDLE, hold_cnt = 0, last = 2 (requester 0 has first priority).
REQ-030 Assertion of rst SHALL take effect asynchronously, including mid-grant; deassertion is synchronised to clk inside the block, and the first arbitration occurs at least one edge after rst rises.

Verification
REQ-031 rst low 3 cycles, then high, req=000 -> grant=000, led=00, busy=0 for 10 cycles.
REQ-032 req=111 from IDLE, held high -> grant sequence 001, 010, 100, 001, each lasting 16 cycles, with switch_p pulsing at each change.
REQ-033 req=010 for 1 cycle only, data1=A5 -> grant=010 for exactly 4 cycles; led=A5 from the cycle after grant rises; afterwards grant=000 and led stays A5.
REQ-034 req0 held alone, data0 stepping 00..1F each cycle -> grant=001 indefinitely and led equals data0 delayed by one cycle.
REQ-035 Owner 0 granted; req2 rises when hold_cnt=5 -> grant=100 at cycle 16 of owner 0's grant, with no cycle at grant=000.
REQ-036 rst pulled low mid-grant, between edges -> grant=000 and led=00 immediately, without waiting for a clk edge; after release, req=111 yields grant=001 first.
